// File: rtl/jpeg_pkg.sv
// Shared constants for the JPEG quantize/zigzag stage: luminance table, its
// 16-bit reciprocals (round(65536/Q)), the zigzag-to-raster map and reader states.
package jpeg_pkg;

    localparam int COEF_W = 12;
    localparam int BLK_N  = 64;

    typedef enum logic {
        IDLE,
        READ
    } rd_state_t;

    localparam logic [7:0] Q_LUMA [BLK_N] = '{
        8'd16,  8'd11,  8'd10,  8'd16,  8'd24,  8'd40,  8'd51,  8'd61,
        8'd12,  8'd12,  8'd14,  8'd19,  8'd26,  8'd58,  8'd60,  8'd55,
        8'd14,  8'd13,  8'd16,  8'd24,  8'd40,  8'd57,  8'd69,  8'd56,
        8'd14,  8'd17,  8'd22,  8'd29,  8'd51,  8'd87,  8'd80,  8'd62,
        8'd18,  8'd22,  8'd37,  8'd56,  8'd68,  8'd109, 8'd103, 8'd77,
        8'd24,  8'd35,  8'd55,  8'd64,  8'd81,  8'd104, 8'd113, 8'd92,
        8'd49,  8'd64,  8'd78,  8'd87,  8'd103, 8'd121, 8'd120, 8'd101,
        8'd72,  8'd92,  8'd95,  8'd98,  8'd112, 8'd100, 8'd103, 8'd99
    };

    localparam logic [15:0] RECIP_LUMA [BLK_N] = '{
        16'd4096, 16'd5958, 16'd6554, 16'd4096, 16'd2731, 16'd1638, 16'd1285, 16'd1074,
        16'd5461, 16'd5461, 16'd4681, 16'd3449, 16'd2521, 16'd1130, 16'd1092, 16'd1192,
        16'd4681, 16'd5041, 16'd4096, 16'd2731, 16'd1638, 16'd1150, 16'd950,  16'd1170,
        16'd4681, 16'd3855, 16'd2979, 16'd2260, 16'd1285, 16'd753,  16'd819,  16'd1057,
        16'd3641, 16'd2979, 16'd1771, 16'd1170, 16'd964,  16'd601,  16'd636,  16'd851,
        16'd2731, 16'd1872, 16'd1192, 16'd1024, 16'd809,  16'd630,  16'd580,  16'd712,
        16'd1337, 16'd1024, 16'd840,  16'd753,  16'd636,  16'd542,  16'd546,  16'd649,
        16'd910,  16'd712,  16'd690,  16'd669,  16'd585,  16'd655,  16'd636,  16'd662
    };

    localparam logic [5:0] ZZ [BLK_N] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

endpackage

// File: rtl/dct_quant_zigzag_if.sv
// Row-beat input bus from the DCT and quantized zigzag stream to the entropy coder.
interface dct_quant_zigzag_if;
    import jpeg_pkg::*;

    logic signed [COEF_W-1:0] data_in_z0;
    logic signed [COEF_W-1:0] data_in_z1;
    logic signed [COEF_W-1:0] data_in_z2;
    logic signed [COEF_W-1:0] data_in_z3;
    logic signed [COEF_W-1:0] data_in_z4;
    logic signed [COEF_W-1:0] data_in_z5;
    logic signed [COEF_W-1:0] data_in_z6;
    logic signed [COEF_W-1:0] data_in_z7;
    logic                     data_en;

    logic signed [COEF_W-1:0] q_data;
    logic                     q_valid;
    logic                     q_ready;
    logic                     q_sob;
    logic                     q_eob;

    modport master (
        output data_in_z0, data_in_z1, data_in_z2, data_in_z3,
        output data_in_z4, data_in_z5, data_in_z6, data_in_z7,
        output data_en, q_ready,
        input  q_data, q_valid, q_sob, q_eob
    );

    modport slave (
        input  data_in_z0, data_in_z1, data_in_z2, data_in_z3,
        input  data_in_z4, data_in_z5, data_in_z6, data_in_z7,
        input  data_en, q_ready,
        output q_data, q_valid, q_sob, q_eob
    );

endinterface

// File: rtl/quant_round.sv
// Combinational quantizer: |coef| * reciprocal, round half away from zero,
// clip magnitude to 2047 and reapply the sign.
module quant_round
    import jpeg_pkg::*;
(
    input  logic signed [COEF_W-1:0] coef,
    input  logic        [15:0]       recip,
    output logic signed [COEF_W-1:0] q
);

    logic              neg;
    logic [COEF_W-1:0] mag;
    logic [27:0]       prod;
    logic [COEF_W-1:0] m;
    logic [COEF_W-2:0] mag_q;

    // The magnitude is unsigned so -2048 maps cleanly to 2048.
    assign neg   = coef[COEF_W-1];
    assign mag   = neg ? COEF_W'(-coef) : COEF_W'(coef);
    assign prod  = 28'(mag) * 28'(recip);
    assign m     = COEF_W'((prod + 28'd32768) >> 16);
    assign mag_q = m[COEF_W-1] ? '1 : m[COEF_W-2:0];
    assign q     = neg ? -signed'({1'b0, mag_q}) : signed'({1'b0, mag_q});

endmodule

// File: rtl/dct_quant_zigzag.sv
// Quantizes 8x8 DCT blocks with the JPEG luminance table and emits them in zigzag
// order; two 64-entry banks ping-pong between the row writer and the zigzag reader.
module dct_quant_zigzag
    import jpeg_pkg::*;
(
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    dct_quant_zigzag_if.slave bus,
    output logic              overflow
);

    logic signed [COEF_W-1:0] lane     [8];
    logic signed [COEF_W-1:0] bank_mem [2][BLK_N];

    logic [2:0] beat_cnt;
    logic       wr_bank;
    logic       drop_blk;
    logic       drop_beat;
    logic       blk_done;
    logic [1:0] full;
    logic [1:0] full_nxt;

    rd_state_t  rd_state;
    logic [5:0] rd_idx;
    logic       rd_bank;
    logic       advance;
    logic       issue;
    logic       release_rd;

    logic                     s1_valid;
    logic                     s1_sob;
    logic                     s1_eob;
    logic signed [COEF_W-1:0] s1_coef;
    logic        [15:0]       s1_recip;
    logic signed [COEF_W-1:0] quant_val;

    logic signed [COEF_W-1:0] q_data_r;
    logic                     q_valid_r;
    logic                     q_sob_r;
    logic                     q_eob_r;

    assign lane[0] = bus.data_in_z0;
    assign lane[1] = bus.data_in_z1;
    assign lane[2] = bus.data_in_z2;
    assign lane[3] = bus.data_in_z3;
    assign lane[4] = bus.data_in_z4;
    assign lane[5] = bus.data_in_z5;
    assign lane[6] = bus.data_in_z6;
    assign lane[7] = bus.data_in_z7;

    assign advance    = !(q_valid_r && !bus.q_ready);
    assign issue      = (rd_state == READ) && advance;
    assign release_rd = issue && (rd_idx == 6'd63);

    // The drop decision is taken on beat 0 and holds for the remaining beats.
    assign drop_beat = (beat_cnt == 3'd0) ? full[wr_bank] : drop_blk;
    assign blk_done  = bus.data_en && !drop_beat && (beat_cnt == 3'd7);

    always_comb begin
        full_nxt = full;
        if (release_rd) begin
            full_nxt[rd_bank] = 1'b0;
        end
        if (blk_done) begin
            full_nxt[wr_bank] = 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            beat_cnt <= '0;
            wr_bank  <= 1'b0;
            drop_blk <= 1'b0;
            full     <= '0;
            overflow <= 1'b0;
        end else begin
            full <= full_nxt;
            if (bus.data_en) begin
                beat_cnt <= beat_cnt + 3'd1;
                if (beat_cnt == 3'd0) begin
                    drop_blk <= full[wr_bank];
                    if (full[wr_bank]) begin
                        overflow <= 1'b1;
                    end
                end
                if (blk_done) begin
                    wr_bank <= ~wr_bank;
                end
            end
        end
    end

    // Bank storage carries no reset; stale contents are never read before a full flag.
    always_ff @(posedge sys_clk) begin
        if (bus.data_en && !drop_beat) begin
            for (int i = 0; i < 8; i++) begin
                bank_mem[wr_bank][{beat_cnt, 3'(i)}] <= lane[i];
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (issue) begin
            s1_coef  <= bank_mem[rd_bank][ZZ[rd_idx]];
            s1_recip <= RECIP_LUMA[ZZ[rd_idx]];
            s1_sob   <= (rd_idx == 6'd0);
            s1_eob   <= (rd_idx == 6'd63);
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rd_state <= IDLE;
            rd_idx   <= '0;
            rd_bank  <= 1'b0;
        end else begin
            case (rd_state)
                IDLE: begin
                    if (full[rd_bank]) begin
                        rd_state <= READ;
                        rd_idx   <= '0;
                    end
                end
                READ: begin
                    if (advance) begin
                        if (rd_idx == 6'd63) begin
                            rd_bank <= ~rd_bank;
                            rd_idx  <= '0;
                            if (!full[~rd_bank]) begin
                                rd_state <= IDLE;
                            end
                        end else begin
                            rd_idx <= rd_idx + 6'd1;
                        end
                    end
                end
                default: rd_state <= IDLE;
            endcase
        end
    end

    quant_round u_quant_round (
        .coef  (s1_coef),
        .recip (s1_recip),
        .q     (quant_val)
    );

    // Every pipe stage advances together, so a stall freezes S1 and the outputs.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            s1_valid  <= 1'b0;
            q_valid_r <= 1'b0;
            q_data_r  <= '0;
            q_sob_r   <= 1'b0;
            q_eob_r   <= 1'b0;
        end else if (advance) begin
            s1_valid  <= issue;
            q_valid_r <= s1_valid;
            q_data_r  <= s1_valid ? quant_val : '0;
            q_sob_r   <= s1_valid && s1_sob;
            q_eob_r   <= s1_valid && s1_eob;
        end
    end

    assign bus.q_data  = q_data_r;
    assign bus.q_valid = q_valid_r;
    assign bus.q_sob   = q_sob_r;
    assign bus.q_eob   = q_eob_r;

endmodule

// File: tb/tb_dct_quant_zigzag.sv
// Scoreboard bench for dct_quant_zigzag: a reference model built from the JPEG
// luminance table and a walked zigzag pushes expectations; a monitor pops on handshakes.
module tb_dct_quant_zigzag;

    typedef int blk_t [64];

    typedef struct {
        logic signed [11:0] d;
        logic               sob;
        logic               eob;
    } exp_t;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;
    logic overflow;

    dct_quant_zigzag_if bus();

    dct_quant_zigzag dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus),
        .overflow  (overflow)
    );

    always #5 sys_clk = ~sys_clk;

    int q_tab [64] = '{
        16, 11, 10, 16, 24, 40, 51, 61,
        12, 12, 14, 19, 26, 58, 60, 55,
        14, 13, 16, 24, 40, 57, 69, 56,
        14, 17, 22, 29, 51, 87, 80, 62,
        18, 22, 37, 56, 68, 109, 103, 77,
        24, 35, 55, 64, 81, 104, 113, 92,
        49, 64, 78, 87, 103, 121, 120, 101,
        72, 92, 95, 98, 112, 100, 103, 99
    };
    int zz [64];

    exp_t sb [$];
    int   check_cnt = 0;
    int   fail_cnt  = 0;
    int   out_cnt   = 0;
    int   sob_cnt   = 0;
    int   eob_cnt   = 0;
    int   run_len   = 0;
    int   max_run   = 0;
    int   rdy_mode  = 0;

    logic               stalled_prev = 1'b0;
    logic signed [11:0] stall_data;
    logic               stall_sob;
    logic               stall_eob;

    // Zigzag walks anti-diagonals, alternating up-right and down-left.
    task automatic buildZigzag();
        int k;
        int lo;
        int hi;
        k = 0;
        for (int s = 0; s < 15; s++) begin
            lo = (s > 7) ? s - 7 : 0;
            hi = (s < 7) ? s : 7;
            if (s % 2 == 0) begin
                for (int r = hi; r >= lo; r--) begin
                    zz[k] = r * 8 + (s - r);
                    k++;
                end
            end else begin
                for (int r = lo; r <= hi; r++) begin
                    zz[k] = r * 8 + (s - r);
                    k++;
                end
            end
        end
    endtask

    function automatic int refQuant(input int c, input int q);
        int recip;
        int mag;
        int m;
        recip = (2 * 65536 + q) / (2 * q);
        mag   = (c < 0) ? -c : c;
        m     = (mag * recip + 32768) / 65536;
        if (m > 2047) m = 2047;
        return (c < 0) ? -m : m;
    endfunction

    task automatic checkVal(input string name, input int got, input int req);
        check_cnt++;
        if (got != req) begin
            fail_cnt++;
            $display("[TB] FAIL %s got=%0d required=%0d", name, got, req);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        check_cnt++;
        if (sb.size() == 0) begin
            fail_cnt++;
            $display("[TB] FAIL unexpected_output got data=%0d sob=%0b eob=%0b required no output",
                     bus.q_data, bus.q_sob, bus.q_eob);
        end else begin
            e = sb.pop_front();
            if (bus.q_data !== e.d || bus.q_sob !== e.sob || bus.q_eob !== e.eob) begin
                fail_cnt++;
                $display("[TB] FAIL out_%0d got data=%0d sob=%0b eob=%0b required data=%0d sob=%0b eob=%0b",
                         out_cnt, bus.q_data, bus.q_sob, bus.q_eob, e.d, e.sob, e.eob);
            end
        end
        out_cnt++;
    endtask

    task automatic applyStimulus(input blk_t blk, input bit kept, input int max_gap,
                                 input int ovf_exp, input int n_beats);
        exp_t e;
        int   gap;
        if (kept && n_beats == 8) begin
            for (int k = 0; k < 64; k++) begin
                e.d   = 12'(refQuant(blk[zz[k]], q_tab[zz[k]]));
                e.sob = (k == 0);
                e.eob = (k == 63);
                sb.push_back(e);
            end
        end
        for (int v = 0; v < n_beats; v++) begin
            bus.data_in_z0 = 12'(blk[8 * v + 0]);
            bus.data_in_z1 = 12'(blk[8 * v + 1]);
            bus.data_in_z2 = 12'(blk[8 * v + 2]);
            bus.data_in_z3 = 12'(blk[8 * v + 3]);
            bus.data_in_z4 = 12'(blk[8 * v + 4]);
            bus.data_in_z5 = 12'(blk[8 * v + 5]);
            bus.data_in_z6 = 12'(blk[8 * v + 6]);
            bus.data_in_z7 = 12'(blk[8 * v + 7]);
            bus.data_en    = 1'b1;
            @(posedge sys_clk);
            #1;
            bus.data_en = 1'b0;
            if (v == 0 && ovf_exp >= 0) checkVal("overflow_after_beat0", int'(overflow), ovf_exp);
            if (max_gap > 0 && v < n_beats - 1) begin
                gap = $urandom_range(0, max_gap);
                repeat (gap) begin
                    @(posedge sys_clk);
                    #1;
                end
            end
        end
    endtask

    task automatic waitDrain(input int budget);
        int cyc;
        cyc = 0;
        while (sb.size() != 0 && cyc < budget) begin
            @(posedge sys_clk);
            cyc++;
        end
        #1;
        checkVal("drain_pending", sb.size(), 0);
        sb.delete();
        repeat (4) @(posedge sys_clk);
        #1;
    endtask

    task automatic doReset(input string tag);
        bus.data_en = 1'b0;
        sys_rst_n   = 1'b0;
        #1;
        checkVal({tag, "_q_valid"}, int'(bus.q_valid), 0);
        checkVal({tag, "_q_data"}, int'(bus.q_data), 0);
        checkVal({tag, "_q_sob"}, int'(bus.q_sob), 0);
        checkVal({tag, "_q_eob"}, int'(bus.q_eob), 0);
        checkVal({tag, "_overflow"}, int'(overflow), 0);
        sb.delete();
        @(posedge sys_clk);
        #2;
        sys_rst_n = 1'b1;
        @(posedge sys_clk);
        #1;
    endtask

    always @(posedge sys_clk) begin
        #1;
        case (rdy_mode)
            0:       bus.q_ready = 1'b1;
            1:       bus.q_ready = 1'($urandom_range(0, 1));
            default: bus.q_ready = 1'b0;
        endcase
    end

    always @(negedge sys_clk) begin
        if (!sys_rst_n) begin
            stalled_prev = 1'b0;
            run_len      = 0;
        end else begin
            if (stalled_prev) begin
                check_cnt++;
                if (bus.q_valid !== 1'b1 || bus.q_data !== stall_data ||
                    bus.q_sob !== stall_sob || bus.q_eob !== stall_eob) begin
                    fail_cnt++;
                    $display("[TB] FAIL stall_hold got valid=%0b data=%0d required valid=1 data=%0d",
                             bus.q_valid, bus.q_data, stall_data);
                end
            end
            if (bus.q_valid === 1'b1) begin
                run_len++;
                if (run_len > max_run) max_run = run_len;
            end else begin
                run_len = 0;
            end
            if (bus.q_valid === 1'b1 && bus.q_ready === 1'b1) begin
                if (bus.q_sob) sob_cnt++;
                if (bus.q_eob) eob_cnt++;
                checkOutput();
            end
            stalled_prev = (bus.q_valid === 1'b1) && (bus.q_ready !== 1'b1);
            stall_data   = bus.q_data;
            stall_sob    = bus.q_sob;
            stall_eob    = bus.q_eob;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog got timeout required completion");
        $fatal(1, "[TB] simulation timeout");
    end

    initial begin
        blk_t blk;
        int   base;
        int   cyc;

        buildZigzag();
        bus.data_en    = 1'b0;
        bus.data_in_z0 = '0;
        bus.data_in_z1 = '0;
        bus.data_in_z2 = '0;
        bus.data_in_z3 = '0;
        bus.data_in_z4 = '0;
        bus.data_in_z5 = '0;
        bus.data_in_z6 = '0;
        bus.data_in_z7 = '0;
        bus.q_ready    = 1'b1;

        #12;
        checkVal("reset_q_valid", int'(bus.q_valid), 0);
        checkVal("reset_q_data", int'(bus.q_data), 0);
        checkVal("reset_q_sob", int'(bus.q_sob), 0);
        checkVal("reset_q_eob", int'(bus.q_eob), 0);
        checkVal("reset_overflow", int'(overflow), 0);
        @(posedge sys_clk);
        #2;
        sys_rst_n = 1'b1;
        @(posedge sys_clk);
        #1;

        $display("[TB] rounding and latency");
        for (int k = 0; k < 64; k++) blk[k] = 0;
        blk[0] = -1000;
        applyStimulus(blk, 1'b1, 0, -1, 8);
        for (int i = 0; i < 4; i++) begin
            @(negedge sys_clk);
            checkVal($sformatf("latency_edge%0d_q_valid", i), int'(bus.q_valid), (i == 3) ? 1 : 0);
        end
        waitDrain(400);

        $display("[TB] zigzag mapping");
        for (int k = 0; k < 64; k++) blk[k] = 0;
        blk[8] = 60;
        applyStimulus(blk, 1'b1, 3, -1, 8);
        waitDrain(400);

        $display("[TB] backpressure");
        rdy_mode = 1;
        for (int k = 0; k < 64; k++) blk[k] = 16 * k;
        applyStimulus(blk, 1'b1, 2, -1, 8);
        waitDrain(1000);

        $display("[TB] random blocks");
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 64; k++) begin
                if (b == 2) blk[k] = (k % 2 != 0) ? 2047 : -2048;
                else        blk[k] = int'($urandom_range(0, 4095)) - 2048;
            end
            applyStimulus(blk, 1'b1, 3, -1, 8);
            if (b % 2 == 1) waitDrain(1000);
        end
        rdy_mode = 0;

        $display("[TB] back-to-back");
        repeat (2) @(posedge sys_clk);
        #1;
        max_run = 0;
        sob_cnt = 0;
        eob_cnt = 0;
        for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < 64; k++) blk[k] = int'($urandom_range(0, 4095)) - 2048;
            applyStimulus(blk, 1'b1, 0, -1, 8);
        end
        waitDrain(600);
        checkVal("b2b_contiguous_valid", max_run, 128);
        checkVal("b2b_sob_count", sob_cnt, 2);
        checkVal("b2b_eob_count", eob_cnt, 2);

        $display("[TB] overflow");
        rdy_mode = 2;
        repeat (2) @(posedge sys_clk);
        #1;
        for (int b = 0; b < 3; b++) begin
            for (int k = 0; k < 64; k++) blk[k] = int'($urandom_range(0, 4095)) - 2048;
            applyStimulus(blk, b < 2, 0, (b == 2) ? 1 : 0, 8);
        end
        checkVal("overflow_sticky", int'(overflow), 1);
        rdy_mode = 0;
        waitDrain(800);
        repeat (80) @(posedge sys_clk);
        #1;
        checkVal("overflow_still_set", int'(overflow), 1);

        $display("[TB] reset mid-operation");
        for (int k = 0; k < 64; k++) blk[k] = int'($urandom_range(0, 4095)) - 2048;
        applyStimulus(blk, 1'b0, 0, -1, 4);
        doReset("rst_partial");
        base = out_cnt;
        applyStimulus(blk, 1'b1, 0, -1, 8);
        cyc = 0;
        while (out_cnt < base + 30 && cyc < 500) begin
            @(posedge sys_clk);
            #2;
            cyc++;
        end
        checkVal("reached_index30", int'(out_cnt >= base + 30), 1);
        doReset("rst_output");
        for (int k = 0; k < 64; k++) blk[k] = int'($urandom_range(0, 4095)) - 2048;
        applyStimulus(blk, 1'b1, 1, -1, 8);
        waitDrain(600);

        $display("TB_RESULT checks=%0d failures=%0d", check_cnt, fail_cnt);
        $finish;
    end

endmodule
